// File: rtl/sync_updown_mod_counter.sv
// Synchronous up/down modulo-MODULUS counter with parallel load, count enable and registered wrap/load_err pulses.
// Optional feature: define SYNC_UPDOWN_COUNTER_GRAY_OUT_EN to add the registered Gray-code output q_gray.
module sync_updown_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             load_err
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $fatal(1, "sync_updown_mod_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $fatal(1, "sync_updown_mod_counter: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
    end
  endgenerate

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  // Boundary compares happen on the current q, so q never leaves 0..MODULUS-1.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (load_val > max_val) begin
        q_nxt   = max_val;
        err_nxt = 1'b1;
      end else begin
        q_nxt = load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        if (q == max_val) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          q_nxt    = max_val;
          wrap_nxt = 1'b1;
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
  // Encoded from q_nxt so the Gray image lands in the same cycle as q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_gray <= '0;
    end else begin
      q_gray <= q_nxt ^ (q_nxt >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Bench for sync_updown_mod_counter: MODULUS=10 and MODULUS=16 instances share stimulus and are
// compared against an arithmetic reference model of the counting rules.
module tb_sync_updown_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q10, q16;
  logic       wrap10, wrap16;
  logic       err10, err16;
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
  logic [3:0] g10, g16;
`endif

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  int m10_q = 0, m10_w = 0, m10_e = 0;
  int m16_q = 0, m16_w = 0, m16_e = 0;

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q10),
    .wrap     (wrap10),
    .load_err (err10)
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
    ,
    .q_gray   (g10)
`endif
  );

  sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q16),
    .wrap     (wrap16),
    .load_err (err16)
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
    ,
    .q_gray   (g16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: counting rules expressed with integer modulo arithmetic.
  function automatic void model(input int m, input int qin, input logic r, input logic ld,
                                input int lv, input logic e, input logic ud,
                                output int qo, output int wo, output int eo);
    qo = qin;
    wo = 0;
    eo = 0;
    if (r) begin
      qo = 0;
    end else if (ld) begin
      if (lv > m - 1) begin
        qo = m - 1;
        eo = 1;
      end else begin
        qo = lv;
      end
    end else if (e) begin
      if (ud) begin
        wo = ((qin + 1) == m) ? 1 : 0;
        qo = (qin + 1) % m;
      end else begin
        wo = (qin == 0) ? 1 : 0;
        qo = (qin + m - 1) % m;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input int lv, input logic e, input logic ud);
    int nq, nw, ne;
    reset    = r;
    load     = ld;
    load_val = lv[3:0];
    en       = e;
    up_dn    = ud;
    @(posedge clk);
    #1;
    step_no++;
    model(10, m10_q, r, ld, lv, e, ud, nq, nw, ne);
    m10_q = nq; m10_w = nw; m10_e = ne;
    model(16, m16_q, r, ld, lv, e, ud, nq, nw, ne);
    m16_q = nq; m16_w = nw; m16_e = ne;
    check("q_m10",    {28'd0, q10},   m10_q);
    check("wrap_m10", {31'd0, wrap10}, m10_w);
    check("err_m10",  {31'd0, err10},  m10_e);
    check("q_m16",    {28'd0, q16},   m16_q);
    check("wrap_m16", {31'd0, wrap16}, m16_w);
    check("err_m16",  {31'd0, err16},  m16_e);
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
    check("gray_m10", {28'd0, g10}, m10_q ^ (m10_q >> 1));
    check("gray_m16", {28'd0, g16}, m16_q ^ (m16_q >> 1));
`endif
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    #2;

    // reset, then count up through the modulus-10 boundary
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

    // load 3 then count down across zero
    step(0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

    // out-of-range load clamps, then a legal load
    step(0, 1, 12, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0);

    // reset beats load; load beats count
    step(0, 1, 7, 0, 1);
    step(1, 1, 2, 1, 1);
    step(0, 1, 2, 1, 1);
    step(0, 0, 0, 1, 1);

    // hold at 15 with en low, then wrap on re-enable
    step(0, 1, 15, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);

    // full modulus-16 sweep with direction changes after it
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_UPDOWN_COUNTER_GRAY_OUT_EN
      logic [3:0] prev_g;
      prev_g = g16;
      step(0, 0, 0, 1, 1);
      check("gray_1bit", $countones(g16 ^ prev_g), 1);
`else
      step(0, 0, 0, 1, 1);
`endif
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_updown_mod_counter.md
# sync_updown_mod_counter

Synchronous, parametrised up/down modulo-N counter with parallel load, count enable and a registered wrap pulse. It generalises the 4-bit binary ripple counter to a single-clock, glitch-free design of any width and modulus. It is the common counter primitive for dividers, timers and sequence generators in the counters block set.

## Interface
- `WIDTH`, 4: counter width in bits; legal range 1..16.
- `MODULUS`, 16: count sequence length; legal range 2..2^WIDTH. Counts 0..MODULUS-1.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `en`  input  1  count enable; when high, `q` steps by one per cycle.
- `up_dn`  input  1  direction; 1 = count up, 0 = count down.
- `load`  input  1  parallel load strobe.
- `load_val`  input  WIDTH  value to load.
- `q`  output  WIDTH  registered count value.
- `wrap`  output  1  registered one-cycle pulse; the count crossed the modulus boundary on the last edge.
- `load_err`  output  1  registered one-cycle pulse; the last load was out of range and was clamped.

## Operation
- Priority at each rising edge: `reset` > `load` > `en`. `up_dn` is don't-care unless `en` is high and `load` is low.
- Reset: `q` = 0, `wrap` = 0, `load_err` = 0.
- Load: if `load_val` <= MODULUS-1, then `q` = `load_val` and `load_err` = 0. Otherwise `q` = MODULUS-1 and `load_err` = 1. A load never asserts `wrap`.
- Count up (en=1, up_dn=1): if `q` = MODULUS-1, then `q` = 0 and `wrap` = 1. Otherwise `q` = `q`+1 and `wrap` = 0.
- Count down (en=1, up_dn=0): if `q` = 0, then `q` = MODULUS-1 and `wrap` = 1. Otherwise `q` = `q`-1 and `wrap` = 0.
- Hold (en=0, load=0): `q` holds; `wrap` and `load_err` are 0.
- Arithmetic is WIDTH bits wide. Because the modulus compare happens before the increment, `q` never takes a value >= MODULUS. When MODULUS = 2^WIDTH this reduces to natural binary wrap.
- A direction change mid-count takes effect on the next enabled edge, with no extra latency.
- MODULUS outside the legal range is a configuration error; the elaboration check fails simulation with $fatal.

## Timing
- Latency: `q`, `wrap` and `load_err` all update on the same rising edge that samples the controls. Every output is a flop with no combinational path from inputs.
- `wrap` is high for exactly one cycle per boundary crossing, aligned with the cycle in which `q` shows the wrapped value (0 up, MODULUS-1 down).
- With `en` held high, `wrap` is periodic with period MODULUS cycles.
- If `reset` is asserted mid-count, `q` = 0 on that edge and any pending `wrap`/`load_err` pulse is cleared. Counting resumes on the first edge with `reset` low.
- If `load` and `en` are high together, the load wins and no count step occurs on that edge.
- If `reset` and `load` are high together, reset wins and `load_err` = 0.

## Configuration
- Macro `SYNC_UPDOWN_COUNTER_GRAY_OUT_EN`.
- Defined: adds the output `q_gray` (WIDTH bits), a registered Gray-code image of the next `q`, equal to q ^ (q >> 1) in the same cycle as `q`. Its reset value is 0.
- Successive `q_gray` values differ in exactly one bit when MODULUS = 2^WIDTH. This single-bit property is not guaranteed at wrap for other moduli.
- Undefined: the `q_gray` port and its flops are absent; all other behaviour is identical.

## Test plan
- WIDTH=4, MODULUS=10. Apply reset for 1 cycle, then en=1, up_dn=1 for 12 cycles. Required: `q` runs 1..9, 0, 1, 2; `wrap` = 1 only in the cycle `q` = 0.
- WIDTH=4, MODULUS=10. Load 3, then en=1, up_dn=0 for 5 cycles. Required: `q` runs 2, 1, 0, 9, 8; `wrap` = 1 only when `q` = 9.
- WIDTH=4, MODULUS=10. Pulse load with load_val=12. Required: `q` = 9 and `load_err` = 1 for one cycle. Then load_val=5 gives `q` = 5 and `load_err` = 0.
- WIDTH=4, MODULUS=10, `q` = 7, en=1. Assert load=1 (load_val=2) together with reset=1. Required: `q` = 0. Next, load=1 with en=1 gives `q` = 2, with no increment.
- WIDTH=4, MODULUS=16, en=1, up_dn=1, toggle en low for 3 cycles at `q` = 15. Required: `q` holds at 15 and `wrap` = 0 while disabled. On re-enable, `q` = 0 and `wrap` = 1.
- With `SYNC_UPDOWN_COUNTER_GRAY_OUT_EN` defined, WIDTH=4, MODULUS=16, count up 16 cycles. Required: `q_gray` runs 0001, 0011, 0010, ..., 1000, 0000, with exactly one bit change per cycle.
